// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receive FIFO and its producer/consumer.
// Latency: none, this is wiring only.
// Backpressure: the consumer pops with rd; the producer cannot be stalled, so full writes are dropped and flagged.
//
// Signals: wr/w_data from the receiver (rx_done/rx_dout), rd/clr_overrun from the host,
// r_data/empty/full/count/overrun back to the host.
// Optional macro UART_RX_FIFO_ALMOST_EN adds almost_full for RTS-style flow control.
interface uart_rx_fifo_if #(
    parameter int DBIT       = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic [DBIT-1:0]       w_data;
    logic                  rd;
    logic                  clr_overrun;
    logic [DBIT-1:0]       r_data;
    logic                  empty;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overrun;
`ifdef UART_RX_FIFO_ALMOST_EN
    logic                  almost_full;
`endif

    // Producer/consumer side.
    modport master (
`ifdef UART_RX_FIFO_ALMOST_EN
        input  almost_full,
`endif
        output wr, w_data, rd, clr_overrun,
        input  r_data, empty, full, count, overrun
    );

    // FIFO side.
    modport slave (
`ifdef UART_RX_FIFO_ALMOST_EN
        output almost_full,
`endif
        input  wr, w_data, rd, clr_overrun,
        output r_data, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO for UART words, first-word-fall-through read data.
// Latency: a word written on edge N is on r_data (empty=0) right after edge N.
// Backpressure: none toward the receiver; writes while full are dropped and set sticky overrun.
//
// Ports: clk (rising edge), rst (synchronous, active high), bus (uart_rx_fifo_if.slave):
//   wr/w_data write strobe + data, rd pop request, clr_overrun clears overrun,
//   r_data oldest word (0 while empty), empty/full/count status, overrun sticky drop flag.
// Optional macro UART_RX_FIFO_ALMOST_EN adds parameter AF_LEVEL and registered almost_full.
module uart_rx_fifo #(
    parameter int DBIT       = 8,
    parameter int ADDR_WIDTH = 4
`ifdef UART_RX_FIFO_ALMOST_EN
    ,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2
`endif
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    logic [DBIT-1:0] mem_q [DEPTH];

    ptr_t w_ptr_q, w_ptr_d;
    ptr_t r_ptr_q, r_ptr_d;
    cnt_t count_q, count_d;
    logic empty_q, empty_d;
    logic full_q,  full_d;
    logic overrun_q, overrun_d;
`ifdef UART_RX_FIFO_ALMOST_EN
    logic almost_full_q, almost_full_d;
`endif

    logic do_rd;
    logic do_wr;
    logic drop;

    always_comb begin
        // A read while empty is ignored; when full, a simultaneous read frees
        // the slot the write needs, so the write is only dropped without rd.
        do_rd = bus.rd && !empty_q;
        do_wr = bus.wr && (!full_q || do_rd);
        drop  = bus.wr && !do_wr;

        w_ptr_d   = w_ptr_q;
        r_ptr_d   = r_ptr_q;
        overrun_d = overrun_q;

        if (do_wr) w_ptr_d = w_ptr_q + ptr_t'(1);
        if (do_rd) r_ptr_d = r_ptr_q + ptr_t'(1);

        count_d = count_q + cnt_t'(do_wr) - cnt_t'(do_rd);

        // Flags are recomputed from the next count so they stay registered
        // and never depend on pointer equality (which is ambiguous at wrap).
        empty_d = (count_d == cnt_t'(0));
        full_d  = (count_d == cnt_t'(DEPTH));

        // A drop in the same cycle as a clear must still be reported.
        if (drop)
            overrun_d = 1'b1;
        else if (bus.clr_overrun)
            overrun_d = 1'b0;

`ifdef UART_RX_FIFO_ALMOST_EN
        almost_full_d = (count_d >= cnt_t'(AF_LEVEL));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_FIFO_ALMOST_EN
            almost_full_q <= 1'b0;
`endif
        end else begin
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
`ifdef UART_RX_FIFO_ALMOST_EN
            almost_full_q <= almost_full_d;
`endif
        end
    end

    // Storage is deliberately not reset; rst only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && do_wr)
            mem_q[w_ptr_q] <= bus.w_data;
    end

    // Forced to 0 while empty so stale or uninitialised storage never leaks out.
    assign bus.r_data  = empty_q ? '0 : mem_q[r_ptr_q];
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.count   = count_q;
    assign bus.overrun = overrun_q;
`ifdef UART_RX_FIFO_ALMOST_EN
    assign bus.almost_full = almost_full_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus scoreboard monitor.
// Latency: model state advances on each rising edge, DUT sampled on the falling edge.
// Backpressure: model drops writes while it holds DEPTH words and no read frees a slot.
module tb_uart_rx_fifo;
    localparam int DBIT  = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_ALMOST_EN
    localparam int AF    = 14;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DBIT(DBIT), .ADDR_WIDTH(AW)) bus ();

    uart_rx_fifo #(
        .DBIT(DBIT),
        .ADDR_WIDTH(AW)
`ifdef UART_RX_FIFO_ALMOST_EN
        , .AF_LEVEL(AF)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: word count, sticky flag, and the expected-word queue.
    int        m_cnt = 0;
    bit        m_ovr = 1'b0;
    bit        chk_en = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus. Called just after a rising edge; returns just after the next.
    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rdv, input bit clr);
        bit rd_ok;
        bit wr_ok;
        rst             = r;
        bus.wr          = w;
        bus.w_data      = d;
        bus.rd          = rdv;
        bus.clr_overrun = clr;
        rd_ok = !r && rdv && (m_cnt > 0);
        wr_ok = !r && w && ((m_cnt < DEPTH) || rd_ok);
        if (wr_ok) exp_q.push_back(d);
        @(posedge clk);
        if (r) begin
            m_cnt = 0;
            m_ovr = 1'b0;
            exp_q.delete();
        end else begin
            m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
            if (w && !wr_ok)
                m_ovr = 1'b1;
            else if (clr)
                m_ovr = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (m_cnt > 0) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: status against the model every cycle; pops and compares on each DUT read.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count",   32'(bus.count),   32'(m_cnt));
            check("empty",   32'(bus.empty),   32'(m_cnt == 0));
            check("full",    32'(bus.full),    32'(m_cnt == DEPTH));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
`ifdef UART_RX_FIFO_ALMOST_EN
            check("almost_full", 32'(bus.almost_full), 32'(m_cnt >= AF));
`endif
            if (m_cnt == 0)
                check("r_data_when_empty", 32'(bus.r_data), 32'h0);
            if (bus.rd === 1'b1 && bus.empty === 1'b0 && rst === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_data: DUT presented %0h but no word expected", bus.r_data);
                end else begin
                    check("rd_data", 32'(bus.r_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.wr = 1'b0; bus.w_data = '0; bus.rd = 1'b0; bus.clr_overrun = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;

        // Single word.
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        check("single_rdata", 32'(bus.r_data), 32'hA5);
        idle();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();

        // Fill to full, then a dropped 17th write.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(bus.full), 32'h1);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("fill_overrun", 32'(bus.overrun), 32'h1);
        check("fill_count", 32'(bus.count), 32'd16);
        // Simultaneous read/write while full.
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        check("full_rw_count", 32'(bus.count), 32'd16);
        drain();
        // Simultaneous read/write while empty: write only.
        step(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        check("empty_rw_rdata", 32'(bus.r_data), 32'h33);
        check("empty_rw_count", 32'(bus.count), 32'd1);
        drain();

        // Reads while empty are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        // Clear overrun in the same cycle as a drop: set wins. Then clear alone.
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
        check("drop_and_clr", 32'(bus.overrun), 32'h1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_alone", 32'(bus.overrun), 32'h0);
        drain();

        // Interleaved write/read pairs, pointers wrap more than twice.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end

`ifdef UART_RX_FIFO_ALMOST_EN
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        check("af_13", 32'(bus.almost_full), 32'h0);
        step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        check("af_14", 32'(bus.almost_full), 32'h1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("af_read", 32'(bus.almost_full), 32'h0);
        drain();
`endif

        // Randomized traffic in phases biased toward filling and draining.
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            int rp;
            wp = (ph % 2 == 0) ? 80 : 30;
            rp = (ph % 2 == 0) ? 30 : 80;
            for (int c = 0; c < 150; c++) begin
                step(1'b0,
                     $urandom_range(0, 99) < wp,
                     8'($urandom),
                     $urandom_range(0, 99) < rp,
                     $urandom_range(0, 99) < 5);
            end
        end

        // Reset after random activity, held two cycles.
        for (int c = 0; c < 20; c++)
            step(1'b0, 1'b1, 8'($urandom), $urandom_range(0, 3) == 0, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_empty",   32'(bus.empty),   32'h1);
        check("rst_full",    32'(bus.full),    32'h0);
        check("rst_count",   32'(bus.count),   32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        check("rst_rdata",   32'(bus.r_data),  32'h0);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each received word on the receiver's one-cycle done strobe and holds it until the host or bus side reads it. It is a synchronous circular FIFO with first-word-fall-through read data, full/empty/count status and a sticky overrun flag for words lost while full. It runs on the same clock as the receiver and the baud tick logic.

Parameters:
DBIT, 8, data word width; must equal the receiver's DBIT.
ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH (16 by default).

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
wr  input  1  write strobe, driven by the receiver's rx_done (1-cycle pulse)
w_data  input  DBIT  write data, driven by the receiver's rx_dout
rd  input  1  read/pop request from the consumer
r_data  output  DBIT  oldest stored word, valid whenever empty=0
empty  output  1  FIFO holds 0 words
full  output  1  FIFO holds 2**ADDR_WIDTH words
count  output  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH
overrun  output  1  sticky: a write was dropped because the FIFO was full
clr_overrun  input  1  clears overrun

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: empty=1, full=0, count=0, overrun=0, write and read pointers=0. Storage contents are not reset.
- r_data reflects mem[r_ptr] combinationally (FWFT). It has no defined value while empty=1, but it must not be X after reset in simulation, so drive 0 when empty.
- Pointers are ADDR_WIDTH bits and wrap naturally from 2**ADDR_WIDTH-1 to 0. full and empty are registered flags, not derived from pointer equality alone.
- Per-cycle actions, evaluated in order, with rst taking priority over everything:
  - wr=1, rd=0, not full: store w_data at w_ptr, w_ptr+1, count+1, empty<=0; full<=1 if the new count equals depth.
  - wr=1, rd=0, full: data dropped, pointers and count unchanged, overrun<=1.
  - wr=0, rd=1, not empty: r_ptr+1, count-1, full<=0; empty<=1 if the new count is 0.
  - wr=0, rd=1, empty: ignored; no state change and no flag.
  - wr=1, rd=1, not empty (including full): write and read both happen, count and flags unchanged, no overrun.
  - wr=1, rd=1, empty: write only (rd ignored); count becomes 1, empty<=0. r_data shows w_data on the next cycle.
- Write-to-read latency: a word written at edge N is visible on r_data with empty=0 after edge N.
- overrun: set on a dropped write, cleared by clr_overrun=1. If a drop and clr_overrun happen in the same cycle, set wins.
- count always equals the number of words written minus words read, modulo drops.

Optional Feature:
Macro UART_RX_FIFO_ALMOST_EN.
- When defined: adds parameter AF_LEVEL (default 2**ADDR_WIDTH-2) and output almost_full (1 bit). almost_full is registered, equals (count >= AF_LEVEL) after each update, and resets to 0. It is intended for RTS-style flow control.
- When not defined: no AF_LEVEL parameter, no almost_full port; the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles after random activity -> empty=1, full=0, count=0, overrun=0, r_data=0.
- Single word: wr pulse with w_data=8'hA5 -> next cycle empty=0, count=1, r_data=8'hA5. Then rd=1 for 1 cycle -> empty=1, count=0.
- Fill to full: 16 writes of 8'h00..8'h0F -> full=1, count=16. A 17th write of 8'hFF -> overrun=1, count=16. Reading 16 words returns 8'h00..8'h0F in order, not 8'hFF; then empty=1.
- Simultaneous access: with full=1, wr=1 + rd=1 with 8'h55 -> count stays 16, no overrun, and 8'h55 is the last word read out. With empty=1, wr=1 + rd=1 with 8'h33 -> count=1, r_data=8'h33.
- Wrap-around and underflow: 40 interleaved write/read pairs, pointers wrapping at least twice -> data in order. rd while empty -> no change to count or flags. Assert clr_overrun in the same cycle as a dropped write -> overrun stays 1; assert clr_overrun alone -> overrun=0.
- With UART_RX_FIFO_ALMOST_EN and AF_LEVEL=14: 13 writes -> almost_full=0; 14th write -> almost_full=1; one read -> almost_full=0.
